uart_rx_unit: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx_unit.sv | 140 ++++++++++++++
 tb/tb_uart_rx_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   LEN_DATA   : default number of data bits per frame
//   NUM_TICKS  : default oversampling ticks per bit period
//   rx_state_t : receiver FSM state encoding
//   width_of() : counter width helper (never returns less than 1 bit)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int LEN_DATA  = 8;
  localparam int NUM_TICKS = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Width of a counter that runs 0 .. value-1.
  function automatic int width_of(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-stage synchronizer for asynchronous inputs.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; both stages load RESET_VALUE
//   d     : asynchronous input
//   q     : synchronized output (two clk of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// ---------------------------------------------------------------------------
// uart_rx_unit
// Oversampled 8N1 UART receiver, LSB first. Feeds the interface circuit that
// loads ALU operands A, B and OPCODE.
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high
//   s_tick       : oversampling enable, NUM_TICKS pulses per bit period
//   rx           : asynchronous serial line, idles high
//   data_out     : last correctly framed byte
//   rx_done_tick : one-clk strobe, data_out has just been updated
//   frame_error  : one-clk strobe, stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx_unit #(
  parameter int NBITS     = uart_pkg::LEN_DATA,
  parameter int NUM_TICKS = uart_pkg::NUM_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             rx,
  output logic [NBITS-1:0] data_out,
  output logic             rx_done_tick,
  output logic             frame_error
);

  import uart_pkg::*;

  localparam int S_W = width_of(NUM_TICKS);
  localparam int N_W = width_of(NBITS);

  localparam logic [S_W-1:0] S_MID  = S_W'(NUM_TICKS / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(NUM_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NBITS - 1);

  rx_state_t        state;
  logic [S_W-1:0]   s;
  logic [N_W-1:0]   n;
  logic [NBITS-1:0] b;
  logic             rx_sync;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      data_out     <= '0;
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one clk.
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            s     <= '0;
          end
        end

        // Re-check the line at the middle of the start bit to reject glitches;
        // from here on every sample lands mid-bit.
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_sync) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        // Shift in from the top so the first (LSB) bit ends up in b[0].
        DATA: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= {rx_sync, b[NBITS-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              if (rx_sync) begin
                data_out     <= b;
                rx_done_tick <= 1'b1;
                state        <= IDLE;
              end else begin
                frame_error <= 1'b1;
                state       <= WAIT_IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        // A held-low line (break) must not be decoded as a run of 0x00 frames.
        WAIT_IDLE: begin
          if (rx_sync) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_unit
// Directed self-checking bench for uart_rx_unit: s_tick every 4 clk,
// NUM_TICKS = 16, so one bit period is 64 clk.
// ---------------------------------------------------------------------------
module tb_uart_rx_unit;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done_tick;
  logic       frame_error;

  logic [1:0] tick_cnt = 2'd0;

  int check_count = 0;
  int error_count = 0;

  int         done_count = 0;
  int         ferr_count = 0;
  int         both_high  = 0;
  int         long_pulse = 0;
  logic       prev_done  = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] data_log [0:63];

  uart_rx_unit #(
    .NBITS    (8),
    .NUM_TICKS(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .data_out    (data_out),
    .rx_done_tick(rx_done_tick),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Baud generator stand-in: one clk-wide pulse every 4 clk.
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign s_tick = (tick_cnt == 2'd3);

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      if (done_count < 64) data_log[done_count] = data_out;
      done_count = done_count + 1;
      if (prev_done) long_pulse = long_pulse + 1;
    end
    if (frame_error) begin
      ferr_count = ferr_count + 1;
      if (prev_ferr) long_pulse = long_pulse + 1;
    end
    if (rx_done_tick && frame_error) both_high = both_high + 1;
    prev_done = rx_done_tick;
    prev_ferr = frame_error;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count = check_count + 1;
    if (observed !== expected) begin
      error_count = error_count + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int count);
    repeat (count) @(negedge clk);
  endtask

  task automatic driveBit(input logic level, input int clocks);
    rx = level;
    waitClocks(clocks);
  endtask

  // One frame: start bit, 8 data bits LSB first, stop level held stop_bits periods.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_level,
                               input int stop_bits);
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) driveBit(value[i], BIT_CLKS);
    driveBit(stop_level, BIT_CLKS * stop_bits);
    rx = 1'b1;
  endtask

  int         base;
  int         ferr_base;
  logic [7:0] seq [0:2];

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    waitClocks(4);
    checkOutput("reset_data", 32'(data_out), 32'h00);
    checkOutput("reset_done", 32'(rx_done_tick), 32'h0);
    checkOutput("reset_ferr", 32'(frame_error), 32'h0);
    reset = 1'b0;
    waitClocks(40);

    // Valid frame
    base = done_count;
    applyStimulus(8'hA5, 1'b1, 1);
    waitClocks(16);
    checkOutput("a5_strobes", 32'(done_count - base), 32'd1);
    checkOutput("a5_data", 32'(data_out), 32'hA5);
    checkOutput("a5_ferr", 32'(ferr_count), 32'd0);
    checkOutput("a5_pulse_width", 32'(long_pulse), 32'd0);

    // Glitch of 3 s_ticks
    base = done_count;
    rx = 1'b0;
    waitClocks(12);
    rx = 1'b1;
    waitClocks(2 * BIT_CLKS);
    checkOutput("glitch_strobes", 32'(done_count - base), 32'd0);
    checkOutput("glitch_ferr", 32'(ferr_count), 32'd0);
    checkOutput("glitch_data_hold", 32'(data_out), 32'hA5);
    applyStimulus(8'h3C, 1'b1, 1);
    waitClocks(16);
    checkOutput("after_glitch_strobes", 32'(done_count - base), 32'd1);
    checkOutput("after_glitch_data", 32'(data_out), 32'h3C);

    // Framing error: stop held low for two bit periods
    base      = done_count;
    ferr_base = ferr_count;
    applyStimulus(8'h5A, 1'b0, 2);
    waitClocks(BIT_CLKS);
    checkOutput("ferr_pulses", 32'(ferr_count - ferr_base), 32'd1);
    checkOutput("ferr_no_done", 32'(done_count - base), 32'd0);
    checkOutput("ferr_data_hold", 32'(data_out), 32'h3C);
    applyStimulus(8'h0F, 1'b1, 1);
    waitClocks(16);
    checkOutput("after_ferr_data", 32'(data_out), 32'h0F);
    checkOutput("after_ferr_strobes", 32'(done_count - base), 32'd1);
    waitClocks(BIT_CLKS);

    // Back-to-back frames, one stop bit each
    base      = done_count;
    ferr_base = ferr_count;
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h81;
    for (int i = 0; i < 3; i++) applyStimulus(seq[i], 1'b1, 1);
    waitClocks(16);
    checkOutput("b2b_strobes", 32'(done_count - base), 32'd3);
    checkOutput("b2b_ferr", 32'(ferr_count - ferr_base), 32'd0);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("b2b_data%0d", i), 32'(data_log[base + i]), 32'(seq[i]));
    waitClocks(BIT_CLKS);

    // Reset during data bit 4 of 0xC3; transmitter aborts (line released)
    base      = done_count;
    ferr_base = ferr_count;
    driveBit(1'b0, BIT_CLKS);
    driveBit(1'b1, BIT_CLKS);
    driveBit(1'b1, BIT_CLKS);
    driveBit(1'b0, BIT_CLKS);
    driveBit(1'b0, BIT_CLKS);
    driveBit(1'b0, BIT_CLKS / 2);
    reset = 1'b1;
    rx    = 1'b1;
    waitClocks(2);
    checkOutput("midreset_data", 32'(data_out), 32'h00);
    checkOutput("midreset_done", 32'(rx_done_tick), 32'h0);
    checkOutput("midreset_ferr", 32'(frame_error), 32'h0);
    reset = 1'b0;
    waitClocks(3 * BIT_CLKS);
    checkOutput("midreset_no_strobe", 32'(done_count - base), 32'd0);
    checkOutput("midreset_no_ferr", 32'(ferr_count - ferr_base), 32'd0);
    applyStimulus(8'h7E, 1'b1, 1);
    waitClocks(16);
    checkOutput("after_reset_data", 32'(data_out), 32'h7E);
    waitClocks(BIT_CLKS);

    // ALU load sequence: A, B, OPCODE
    base = done_count;
    seq[0] = 8'h05; seq[1] = 8'h03; seq[2] = 8'h20;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(seq[i], 1'b1, 1);
      waitClocks(BIT_CLKS / 2);
    end
    checkOutput("alu_strobes", 32'(done_count - base), 32'd3);
    checkOutput("alu_a", 32'(data_log[base]), 32'h05);
    checkOutput("alu_b", 32'(data_log[base + 1]), 32'h03);
    checkOutput("alu_opcode", 32'(data_log[base + 2]), 32'h20);

    // Whole-run strobe properties
    checkOutput("no_overlap", 32'(both_high), 32'd0);
    checkOutput("pulse_width", 32'(long_pulse), 32'd0);
    checkOutput("total_ferr", 32'(ferr_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
